// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the 2-way write-back cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    RESPOND   = 2'd3
  } state_t;

  function automatic int unsigned tag_bits(input int unsigned addr_w,
                                           input int unsigned sets_w,
                                           input int unsigned blocks_w);
    return addr_w - sets_w - blocks_w;
  endfunction

  function automatic int unsigned index_lsb(input int unsigned blocks_w);
    return blocks_w;
  endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: tag/valid/dirty/data storage with an asynchronous read port.
module cache_way #(
  parameter int unsigned LOG_NUM_SETS   = 2,
  parameter int unsigned LOG_NUM_BLOCKS = 1,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TAG_WIDTH      = 5
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [LOG_NUM_SETS-1:0]                       idx,
  output logic [TAG_WIDTH-1:0]                          tag,
  output logic                                          valid,
  output logic                                          dirty,
  output logic [(2**LOG_NUM_BLOCKS)-1:0][DATA_WIDTH-1:0] line,
  input  logic                                          word_we,
  input  logic [LOG_NUM_BLOCKS-1:0]                     word_off,
  input  logic [DATA_WIDTH-1:0]                         word_data,
  input  logic                                          set_dirty,
  input  logic                                          clr_dirty,
  input  logic                                          fill_done,
  input  logic [TAG_WIDTH-1:0]                          fill_tag
);

  localparam int unsigned NUM_SETS   = 2**LOG_NUM_SETS;
  localparam int unsigned NUM_BLOCKS = 2**LOG_NUM_BLOCKS;

  logic [TAG_WIDTH-1:0]                   tag_mem  [NUM_SETS];
  logic [NUM_BLOCKS-1:0][DATA_WIDTH-1:0]  data_mem [NUM_SETS];
  logic [NUM_SETS-1:0]                    valid_mem;
  logic [NUM_SETS-1:0]                    dirty_mem;

  // Status bits are cleared by reset; a fill marks the line valid and clean.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_mem <= '0;
      dirty_mem <= '0;
    end else begin
      if (fill_done) begin
        valid_mem[idx] <= 1'b1;
        dirty_mem[idx] <= 1'b0;
      end
      if (set_dirty) dirty_mem[idx] <= 1'b1;
      if (clr_dirty) dirty_mem[idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (word_we)   data_mem[idx][word_off] <= word_data;
    if (fill_done) tag_mem[idx]            <= fill_tag;
  end

  assign tag   = tag_mem[idx];
  assign valid = valid_mem[idx];
  assign dirty = dirty_mem[idx];
  assign line  = data_mem[idx];

endmodule

// File: rtl/cache_2way_wb.sv
// 2-way set-associative write-back, write-allocate cache with word-beat memory port.
module cache_2way_wb
  import cache_pkg::*;
#(
  parameter int unsigned LOG_NUM_SETS   = 2,
  parameter int unsigned LOG_NUM_BLOCKS = 1,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ready,
  output logic                  cpu_resp_valid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_hit,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned TW  = tag_bits(ADDR_WIDTH, LOG_NUM_SETS, LOG_NUM_BLOCKS);
  localparam int unsigned LS  = LOG_NUM_SETS;
  localparam int unsigned LB  = LOG_NUM_BLOCKS;
  localparam int unsigned IXL = index_lsb(LOG_NUM_BLOCKS);
  localparam int unsigned NB  = 2**LOG_NUM_BLOCKS;
  localparam int unsigned NS  = 2**LOG_NUM_SETS;

  state_t state, next_state;
  logic [LB-1:0] beat, next_beat;
  logic          victim, nxt_victim;
  logic          req_we, nxt_we;
  logic [ADDR_WIDTH-1:0] req_addr, nxt_addr;
  logic [DATA_WIDTH-1:0] req_wdata, nxt_wdata;
  logic [NS-1:0] lru;

  logic [LB-1:0] cpu_off, req_off;
  logic [LS-1:0] cpu_idx, req_idx, nxt_idx, idx_sel;
  logic [TW-1:0] cpu_tag, req_tag, nxt_tag;

  logic [TW-1:0]                  way_tag  [2];
  logic [1:0]                     way_valid, way_dirty, hit_vec;
  logic [NB-1:0][DATA_WIDTH-1:0]  way_line [2];
  logic accept, hit, hit_way, pick_victim, last_beat;

  logic [1:0]            word_we, set_dirty, clr_dirty, fill_done;
  logic [LB-1:0]         word_off;
  logic [DATA_WIDTH-1:0] word_data;
  logic                  lru_we, lru_val;
  logic ready_d, resp_d, hit_d, mem_req_d, mem_we_d;
  logic [DATA_WIDTH-1:0] rdata_d, mem_wdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;

  assign cpu_off = cpu_addr[LB-1:0];
  assign cpu_idx = cpu_addr[IXL +: LS];
  assign cpu_tag = cpu_addr[ADDR_WIDTH-1 -: TW];
  assign req_off = req_addr[LB-1:0];
  assign req_idx = req_addr[IXL +: LS];
  assign req_tag = req_addr[ADDR_WIDTH-1 -: TW];
  assign idx_sel = (state == IDLE) ? cpu_idx : req_idx;

  for (genvar w = 0; w < 2; w++) begin : g_way
    cache_way #(
      .LOG_NUM_SETS(LS), .LOG_NUM_BLOCKS(LB), .DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TW)
    ) u_way (
      .clk(clk), .rst(rst), .idx(idx_sel),
      .tag(way_tag[w]), .valid(way_valid[w]), .dirty(way_dirty[w]), .line(way_line[w]),
      .word_we(word_we[w]), .word_off(word_off), .word_data(word_data),
      .set_dirty(set_dirty[w]), .clr_dirty(clr_dirty[w]),
      .fill_done(fill_done[w]), .fill_tag(req_tag)
    );
    assign hit_vec[w] = way_valid[w] && (way_tag[w] == cpu_tag);
  end

  assign accept      = cpu_req && cpu_ready;
  assign hit         = |hit_vec;
  assign hit_way     = hit_vec[1];
  assign pick_victim = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru[cpu_idx]);
  assign last_beat   = (beat == '1);

  // Request fields as they will be after this edge (latched on acceptance).
  assign nxt_victim = (state == IDLE && accept) ? pick_victim : victim;
  assign nxt_addr   = (state == IDLE && accept) ? cpu_addr  : req_addr;
  assign nxt_we     = (state == IDLE && accept) ? cpu_we    : req_we;
  assign nxt_wdata  = (state == IDLE && accept) ? cpu_wdata : req_wdata;
  assign nxt_idx    = nxt_addr[IXL +: LS];
  assign nxt_tag    = nxt_addr[ADDR_WIDTH-1 -: TW];

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    next_beat  = beat;
    case (state)
      IDLE: if (accept && !hit) begin
        next_state = (way_valid[pick_victim] && way_dirty[pick_victim]) ? WRITEBACK : REFILL;
        next_beat  = '0;
      end
      WRITEBACK: if (mem_ack) begin
        next_state = last_beat ? REFILL : WRITEBACK;
        next_beat  = last_beat ? '0 : beat + LB'(1);
      end
      REFILL: if (mem_ack) begin
        next_state = last_beat ? RESPOND : REFILL;
        next_beat  = last_beat ? '0 : beat + LB'(1);
      end
      RESPOND: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    word_we     = '0;
    set_dirty   = '0;
    clr_dirty   = '0;
    fill_done   = '0;
    word_off    = cpu_off;
    word_data   = cpu_wdata;
    lru_we      = 1'b0;
    lru_val     = 1'b0;
    resp_d      = 1'b0;
    hit_d       = 1'b0;
    rdata_d     = cpu_rdata;
    ready_d     = (next_state == IDLE);
    mem_req_d   = (next_state == WRITEBACK) || (next_state == REFILL);
    mem_we_d    = (next_state == WRITEBACK);
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (mem_req_d)
      mem_addr_d = {(mem_we_d ? way_tag[nxt_victim] : nxt_tag), nxt_idx, next_beat};
    if (mem_we_d)
      mem_wdata_d = way_line[nxt_victim][next_beat];
    case (state)
      IDLE: if (accept && hit) begin
        resp_d  = 1'b1;
        hit_d   = 1'b1;
        rdata_d = way_line[hit_way][cpu_off];
        lru_we  = 1'b1;
        lru_val = ~hit_way;
        if (cpu_we) begin
          word_we[hit_way]   = 1'b1;
          set_dirty[hit_way] = 1'b1;
        end
      end
      WRITEBACK: if (mem_ack && last_beat) clr_dirty[victim] = 1'b1;
      REFILL: if (mem_ack) begin
        word_we[victim] = 1'b1;
        word_off        = beat;
        word_data       = mem_rdata;
        if (last_beat) begin
          fill_done[victim] = 1'b1;
          lru_we  = 1'b1;
          lru_val = ~victim;
          resp_d  = 1'b1;
          // The requested word may be the one arriving on this very beat.
          rdata_d = (req_off == beat) ? mem_rdata : way_line[victim][req_off];
        end
      end
      RESPOND: if (req_we) begin
        word_we[victim]   = 1'b1;
        set_dirty[victim] = 1'b1;
        word_off          = req_off;
        word_data         = req_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      beat           <= '0;
      victim         <= 1'b0;
      req_we         <= 1'b0;
      req_addr       <= '0;
      req_wdata      <= '0;
      lru            <= '0;
      cpu_ready      <= 1'b0;
      cpu_resp_valid <= 1'b0;
      cpu_hit        <= 1'b0;
      cpu_rdata      <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      beat           <= next_beat;
      victim         <= nxt_victim;
      req_we         <= nxt_we;
      req_addr       <= nxt_addr;
      req_wdata      <= nxt_wdata;
      if (lru_we) lru[idx_sel] <= lru_val;
      cpu_ready      <= ready_d;
      cpu_resp_valid <= resp_d;
      cpu_hit        <= hit_d;
      cpu_rdata      <= rdata_d;
      mem_req        <= mem_req_d;
      mem_we         <= mem_we_d;
      mem_addr       <= mem_addr_d;
      mem_wdata      <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_cache_2way_wb.sv
// Bench for cache_2way_wb: transaction-level cache model, memory responder and directed checks.
module tb_cache_2way_wb;

  localparam int unsigned LS = 2;
  localparam int unsigned LB = 1;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned NS = 4;
  localparam int unsigned NB = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_ready, cpu_resp_valid, cpu_hit;
  logic [AW-1:0] cpu_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
  logic          mem_req, mem_we, mem_ack;

  always #5 clk = ~clk;

  cache_2way_wb #(.LOG_NUM_SETS(LS), .LOG_NUM_BLOCKS(LB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mem [256];

  // Transaction-level cache model
  bit            m_valid [NS][2];
  bit            m_dirty [NS][2];
  int            m_tag   [NS][2];
  logic [DW-1:0] m_data  [NS][2][NB];
  int            m_lru   [NS];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         exp_q[$];
  logic          exp_hit;
  logic [DW-1:0] exp_rdata;
  logic [AW-1:0] obs_addr[$];
  logic          obs_we[$];
  logic [DW-1:0] obs_wdata[$];
  logic          got_hit;
  logic [DW-1:0] got_rdata;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_lru[s] = 0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
  endtask

  task automatic predict(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
    int s, off, tg, way, base;
    s   = (int'(a) >> LB) % NS;
    off = int'(a) % NB;
    tg  = int'(a) >> (LB + LS);
    way = -1;
    exp_q.delete();
    for (int w = 0; w < 2; w++)
      if (m_valid[s][w] && m_tag[s][w] == tg) way = w;
    if (way >= 0) begin
      exp_hit = 1'b1;
    end else begin
      exp_hit = 1'b0;
      way = !m_valid[s][0] ? 0 : (!m_valid[s][1] ? 1 : m_lru[s]);
      if (m_valid[s][way] && m_dirty[s][way])
        for (int o = 0; o < NB; o++) begin
          base = (m_tag[s][way] * NS + s) * NB + o;
          exp_q.push_back('{1'b1, AW'(base), m_data[s][way][o]});
          mem[base] = m_data[s][way][o];
        end
      for (int o = 0; o < NB; o++) begin
        base = (tg * NS + s) * NB + o;
        exp_q.push_back('{1'b0, AW'(base), '0});
        m_data[s][way][o] = mem[base];
      end
      m_valid[s][way] = 1'b1;
      m_dirty[s][way] = 1'b0;
      m_tag[s][way]   = tg;
    end
    exp_rdata = m_data[s][way][off];
    if (we) begin
      m_data[s][way][off] = wd;
      m_dirty[s][way]     = 1'b1;
    end
    m_lru[s] = (way == 0) ? 1 : 0;
  endtask

  // Issue one request, act as memory, and check every cycle until the response.
  task automatic do_req(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd, input int stall);
    int cyc, last_pop, st;
    bit done, acked;
    obs_addr.delete();
    obs_we.delete();
    obs_wdata.delete();
    predict(a, we, wd);
    @(negedge clk);
    cyc = 0;
    while (!cpu_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("ready_before_req", 64'(cpu_ready), 64'(1));
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    @(posedge clk);
    cyc = 0; done = 1'b0; acked = 1'b0; last_pop = -1;
    st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (acked) begin
        acked = 1'b0;
        mem_ack = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        last_pop = cyc;
        st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      end
      mem_ack = 1'b0;
      if (!cpu_ready) begin
        cpu_req = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = AW'($urandom); cpu_wdata = $urandom;
      end else cpu_req = 1'b0;
      if (cpu_resp_valid) begin
        got_hit = cpu_hit;
        got_rdata = cpu_rdata;
        chk("resp_hit", 64'(cpu_hit), 64'(exp_hit));
        if (!we) chk("resp_rdata", 64'(cpu_rdata), 64'(exp_rdata));
        chk("resp_beats_left", 64'(exp_q.size()), 64'(0));
        chk("resp_latency", 64'(cyc), exp_hit ? 64'(1) : 64'(last_pop));
        chk("resp_mem_req", 64'(mem_req), 64'(0));
        done = 1'b1;
      end else if (mem_req) begin
        chk("busy_ready", 64'(cpu_ready), 64'(0));
        if (exp_q.size() == 0) chk("unexpected_mem_req", 64'(mem_req), 64'(0));
        else begin
          chk("beat_addr", 64'(mem_addr), 64'(exp_q[0].addr));
          chk("beat_we", 64'(mem_we), 64'(exp_q[0].we));
          if (exp_q[0].we) chk("beat_wdata", 64'(mem_wdata), 64'(exp_q[0].data));
        end
        if (st == 0) begin
          mem_ack = 1'b1;
          acked = 1'b1;
          mem_rdata = mem[mem_addr];
          obs_addr.push_back(mem_addr);
          obs_we.push_back(mem_we);
          obs_wdata.push_back(mem_wdata);
        end else begin
          st--;
          mem_rdata = $urandom;
        end
      end else begin
        // Stray acks while no beat is outstanding must be ignored.
        mem_ack = 1'($urandom_range(0, 1));
      end
    end
    if (!done) chk("resp_timeout", 64'(done), 64'(1));
    mem_ack = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("resp_pulse_len", 64'(cpu_resp_valid), 64'(0));
    chk("ready_after_resp", 64'(cpu_ready), 64'(1));
  endtask

  task automatic reset_mid_refill();
    int cyc;
    bit found;
    @(negedge clk);
    cyc = 0;
    while (!cpu_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h44; cpu_wdata = '0;
    @(posedge clk);
    found = 1'b0; cyc = 0;
    while (!found && cyc < 50) begin
      @(negedge clk);
      cyc++;
      cpu_req = 1'b0;
      mem_ack = 1'b0;
      if (mem_req && mem_addr == 8'h45) found = 1'b1;
      else if (mem_req) begin
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr];
      end
    end
    chk("rst_second_beat_seen", 64'(found), 64'(1));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem_req", 64'(mem_req), 64'(0));
    chk("rst_mid_resp", 64'(cpu_resp_valid), 64'(0));
    chk("rst_mid_ready", 64'(cpu_ready), 64'(0));
    chk("rst_mid_mem_addr", 64'(mem_addr), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    mem[8'h10] = 32'h000000A0;
    mem[8'h11] = 32'h000000A1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(cpu_ready), 64'(0));
    chk("rst_resp", 64'(cpu_resp_valid), 64'(0));
    chk("rst_hit", 64'(cpu_hit), 64'(0));
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_rdata", 64'(cpu_rdata), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    rst = 1'b1;

    do_req(8'h10, 1'b0, '0, -1);
    chk("cold_beats", 64'(obs_addr.size()), 64'(2));
    chk("cold_beat0", 64'(obs_addr[0]), 64'h10);
    chk("cold_beat1", 64'(obs_addr[1]), 64'h11);
    chk("cold_hit", 64'(got_hit), 64'(0));
    chk("cold_rdata", 64'(got_rdata), 64'hA0);

    do_req(8'h11, 1'b0, '0, -1);
    chk("hit_beats", 64'(obs_addr.size()), 64'(0));
    chk("hit_hit", 64'(got_hit), 64'(1));
    chk("hit_rdata", 64'(got_rdata), 64'hA1);

    do_req(8'h11, 1'b1, 32'hDEADBEEF, -1);
    chk("whit_hit", 64'(got_hit), 64'(1));
    do_req(8'h30, 1'b0, '0, -1);
    do_req(8'h50, 1'b0, '0, -1);
    chk("evict_beats", 64'(obs_addr.size()), 64'(4));
    chk("evict_a0", 64'(obs_addr[0]), 64'h10);
    chk("evict_a1", 64'(obs_addr[1]), 64'h11);
    chk("evict_a2", 64'(obs_addr[2]), 64'h50);
    chk("evict_a3", 64'(obs_addr[3]), 64'h51);
    chk("evict_we0", 64'(obs_we[0]), 64'(1));
    chk("evict_we2", 64'(obs_we[2]), 64'(0));
    chk("evict_d0", 64'(obs_wdata[0]), 64'hA0);
    chk("evict_d1", 64'(obs_wdata[1]), 64'hDEADBEEF);

    do_req(8'h21, 1'b1, 32'h12345678, -1);
    chk("wmiss_beats", 64'(obs_addr.size()), 64'(2));
    chk("wmiss_a0", 64'(obs_addr[0]), 64'h20);
    chk("wmiss_hit", 64'(got_hit), 64'(0));
    do_req(8'h21, 1'b0, '0, -1);
    chk("wmiss_rd_hit", 64'(got_hit), 64'(1));
    chk("wmiss_rd_data", 64'(got_rdata), 64'h12345678);

    do_req(8'h02, 1'b0, '0, 5);
    chk("stall_hit", 64'(got_hit), 64'(0));
    chk("stall_rdata", 64'(got_rdata), 64'hC0DE0002);

    reset_mid_refill();
    do_req(8'h44, 1'b0, '0, -1);
    chk("after_rst_hit", 64'(got_hit), 64'(0));
    chk("after_rst_rdata", 64'(got_rdata), 64'hC0DE0044);

    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
      do_req(a, 1'($urandom_range(0, 1)), $urandom, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
